bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter: WIDTH, default 16, binary input width; legal range 4..32.
REQ-002 Parameter: DIGITS, default 5, number of BCD output digits; legal range 1..10.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  conversion request; sampled only while ready=1.
REQ-006 Port: bin  input  WIDTH  unsigned binary operand; sampled on the accepting edge only.
REQ-007 Port: ready  output  1  high in IDLE; a start is accepted on an edge where ready=1 and start=1.
REQ-008 Port: busy  output  1  high in SHIFT and DONE; equals ~ready.
REQ-009 Port: done  output  1  one-cycle pulse marking bcd/overflow update.
REQ-010 Port: bcd  output  4*DIGITS  result register; digit k occupies bits [4k+3:4k], with digit 0 least significant.
REQ-011 Port: overflow  output  1  high when bin >= 10^DIGITS for the last completed conversion.
REQ-012 Port: seg  output  7*DIGITS  seven-segment pattern per digit; present only under REQ-027.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE.
- IDLE -> SHIFT on an accepted start.
- SHIFT -> DONE after exactly WIDTH shift iterations.
- DONE -> IDLE unconditionally after one cycle.
REQ-014 On the accepting edge, the block SHALL latch bin into a shift register, clear the BCD scratch and the overflow scratch, and load the iteration counter with WIDTH.
REQ-015 Each SHIFT cycle SHALL perform one double-dabble iteration: first add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit.
REQ-016 Any 1 shifted out of the top scratch digit SHALL set the sticky overflow scratch.
REQ-017 Timing for a start accepted at edge N:
- Shifts occur at edges N+1 through N+WIDTH.
- At edge N+WIDTH, bcd and overflow load from the scratch, and state becomes DONE.
- done=1 for exactly the cycle between edges N+WIDTH and N+WIDTH+1.
- ready returns high after edge N+WIDTH+1.
REQ-018 Start asserted while busy=1 SHALL be ignored, not queued; bin changes while busy SHALL NOT affect the result.
REQ-019 bcd and overflow SHALL hold their values between completions and change only at the DONE-entry edge.
REQ-020 With overflow=1, bcd SHALL equal bin mod 10^DIGITS.
REQ-021 Arithmetic widths:
- Scratch width is 4*DIGITS.
- Counter width is clog2(WIDTH+1).
- Digit add-3 is 4-bit with no carry between digits.
REQ-022 Holding start high continuously SHALL give back-to-back conversions, each WIDTH+1 cycles apart from accept to accept, plus one IDLE cycle, i.e. one accept every WIDTH+2 cycles.

Reset
REQ-023 While reset=1, the block SHALL force the following, independent of clk:
- state=IDLE
- ready=1, busy=0, done=0
- bcd=0, overflow=0
- scratch, shift register and counter cleared
- seg = pattern for 0 on every digit
REQ-024 Reset asserted mid-conversion SHALL abort it with no done pulse, and the previous result SHALL be lost.
REQ-025 The first accepted start SHALL occur no earlier than the first rising edge after reset deasserts.

Configuration
REQ-026 Macro BCD_SEVSEG_OUT_EN SHALL control the seg port.
REQ-027 With BCD_SEVSEG_OUT_EN defined:
- seg is present, and each 7-bit field is the active-low combinational decode of the registered bcd digit, bit 6=g and bit 0=a.
- Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Digit values 10..15 decode to 1111111 (blank).
REQ-028 Without BCD_SEVSEG_OUT_EN, the seg port and its decode logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-029 WIDTH=16, DIGITS=5, bin=16'hFFFF, start pulse at edge N -> done high after edge N+16, bcd=20'h65535, overflow=0, ready high after edge N+17.
REQ-030 WIDTH=16, DIGITS=5, bin=0 -> bcd=20'h00000, overflow=0, latency identical to REQ-029.
REQ-031 WIDTH=8, DIGITS=2: bin=8'd255 -> bcd=8'h55, overflow=1; then bin=8'd99 -> bcd=8'h99, overflow=0.
REQ-032 Start bin=16'd1234; while busy, pulse start with bin=16'd9 -> single done, bcd=20'h01234; bcd unchanged until the next accepted conversion completes.
REQ-033 Reset asserted at edge N+5 of a conversion -> outputs immediately at reset values, no done pulse; after release, a new start of bin=16'd42 -> bcd=20'h00042.
REQ-034 With BCD_SEVSEG_OUT_EN, bin=16'd50 -> seg digit0=1000000, digit1=0010010, digits2..4=1000000.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift per cycle, WIDTH shifts per conversion.
// Optional seven-segment outputs are enabled by defining BCD_SEVSEG_OUT_EN.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef BCD_SEVSEG_OUT_EN
    ,
    output logic [7*DIGITS-1:0]   seg
`endif
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [BW-1:0]      scr_q, scr_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovs_q, ovs_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [BW-1:0]      adj;
    logic [BW-1:0]      scr_shifted;
    logic               carry_out;
    logic               last_shift;

    // Add 3 to each digit >= 5; digits are independent 4-bit adds with no carry between them.
    function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] s);
        logic [BW-1:0] r;
        r = s;
        for (int k = 0; k < DIGITS; k++) begin
            if (s[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = s[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign adj         = dabble_adjust(scr_q);
    assign scr_shifted = {adj[BW-2:0], sh_q[WIDTH-1]};
    assign carry_out   = adj[BW-1];
    assign last_shift  = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            scr_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            ovs_q   <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            scr_q   <= scr_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            ovs_q   <= ovs_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_shift) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The final shift result goes straight into bcd/overflow on the DONE-entry edge.
    always_comb begin
        scr_d = scr_q;
        sh_d  = sh_q;
        cnt_d = cnt_q;
        ovs_d = ovs_q;
        bcd_d = bcd_q;
        ovf_d = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d  = bin;
                    scr_d = '0;
                    ovs_d = 1'b0;
                    cnt_d = CNT_W'(WIDTH);
                end
            end
            SHIFT: begin
                scr_d = scr_shifted;
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                ovs_d = ovs_q | carry_out;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_shift) begin
                    bcd_d = scr_shifted;
                    ovf_d = ovs_q | carry_out;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
        busy  = ~ready;
        done  = (state_q == DONE);
    end

    assign bcd      = bcd_q;
    assign overflow = ovf_q;

`ifdef BCD_SEVSEG_OUT_EN
    // Active-low segments, bit 6 = g ... bit 0 = a; non-decimal digits blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    for (genvar k = 0; k < DIGITS; k++) begin : g_seg
        assign seg[7*k +: 7] = seg_decode(bcd_q[4*k +: 4]);
    end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 16-bit/5-digit instance and an 8-bit/2-digit instance.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset;

    logic        start_a;
    logic [15:0] bin_a;
    logic        ready_a, busy_a, done_a, ovf_a;
    logic [19:0] bcd_a;

    logic        start_b;
    logic [7:0]  bin_b;
    logic        ready_b, busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;

`ifdef BCD_SEVSEG_OUT_EN
    logic [34:0] seg_a;
    logic [13:0] seg_b;
`endif

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .bin(bin_a),
        .ready(ready_a), .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
`ifdef BCD_SEVSEG_OUT_EN
        , .seg(seg_a)
`endif
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .bin(bin_b),
        .ready(ready_b), .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
`ifdef BCD_SEVSEG_OUT_EN
        , .seg(seg_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one conversion on dut_a, check the 16-edge latency, the result and the return to idle.
    task automatic conv_a(input logic [15:0] b, input logic [19:0] eb, input logic eo, input string tag);
        int cyc;
        bin_a   = b;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk({tag, "_busy"}, 64'(busy_a), 64'd1);
        cyc = 0;
        while (!done_a && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd16);
        chk({tag, "_bcd"}, 64'(bcd_a), 64'(eb));
        chk({tag, "_ovf"}, 64'(ovf_a), 64'(eo));
        chk({tag, "_ready_in_done"}, 64'(ready_a), 64'd0);
        tick();
        chk({tag, "_done_pulse"}, 64'(done_a), 64'd0);
        chk({tag, "_ready_after"}, 64'(ready_a), 64'd1);
        chk({tag, "_bcd_hold"}, 64'(bcd_a), 64'(eb));
    endtask

    task automatic conv_b(input logic [7:0] b, input logic [7:0] eb, input logic eo, input string tag);
        int cyc;
        bin_b   = b;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 30) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd8);
        chk({tag, "_bcd"}, 64'(bcd_b), 64'(eb));
        chk({tag, "_ovf"}, 64'(ovf_b), 64'(eo));
        tick();
        chk({tag, "_ready_after"}, 64'(ready_b), 64'd1);
    endtask

    initial begin
        int cyc;
        int dones;
        reset   = 1'b1;
        start_a = 1'b0;
        bin_a   = '0;
        start_b = 1'b0;
        bin_b   = '0;
        #3;
        chk("rst_ready", 64'(ready_a), 64'd1);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_bcd", 64'(bcd_a), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
`ifdef BCD_SEVSEG_OUT_EN
        chk("rst_seg", 64'(seg_a), 64'({5{7'b1000000}}));
`endif
        tick();
        tick();
        reset = 1'b0;

        conv_a(16'hFFFF, 20'h65535, 1'b0, "ffff");
        conv_a(16'd0, 20'h00000, 1'b0, "zero");
        conv_a(16'd9999, 20'h09999, 1'b0, "n9999");
        conv_a(16'd10000, 20'h10000, 1'b0, "n10000");

        // Start while busy must be ignored and bin changes must not leak in.
        bin_a   = 16'd1234;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        bin_a   = 16'd9;
        start_a = 1'b1;
        tick();
        tick();
        start_a = 1'b0;
        cyc = 0;
        while (!done_a && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("busy_start_bcd", 64'(bcd_a), 64'h01234);
        chk("busy_start_ovf", 64'(ovf_a), 64'd0);
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done_a) dones++;
        end
        chk("busy_start_no_second_done", 64'(dones), 64'd0);
        chk("busy_start_bcd_held", 64'(bcd_a), 64'h01234);

        // Reset mid-conversion aborts it and loses the previous result.
        bin_a   = 16'd777;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_conv_bcd_held", 64'(bcd_a), 64'h01234);
        chk("mid_conv_busy", 64'(busy_a), 64'd1);
        tick();
        @(posedge clk);
        reset = 1'b1;
        #1;
        chk("abort_ready", 64'(ready_a), 64'd1);
        chk("abort_busy", 64'(busy_a), 64'd0);
        chk("abort_done", 64'(done_a), 64'd0);
        chk("abort_bcd", 64'(bcd_a), 64'd0);
        chk("abort_ovf", 64'(ovf_a), 64'd0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done_a) dones++;
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_a) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        conv_a(16'd42, 20'h00042, 1'b0, "after_abort");

        // Start held high: one accept every WIDTH+2 cycles.
        bin_a   = 16'd500;
        start_a = 1'b1;
        cyc = 0;
        while (!done_a && cyc < 40) begin
            tick();
            cyc++;
        end
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done_a && cyc < 60);
        start_a = 1'b0;
        chk("b2b_spacing", 64'(cyc), 64'd18);
        chk("b2b_bcd", 64'(bcd_a), 64'h00500);
        tick();
        chk("b2b_idle", 64'(ready_a), 64'd1);

`ifdef BCD_SEVSEG_OUT_EN
        conv_a(16'd50, 20'h00050, 1'b0, "seg50");
        chk("seg50_seg", 64'(seg_a),
            64'({7'b1000000, 7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000}));
`endif

        conv_b(8'd255, 8'h55, 1'b1, "b255");
        conv_b(8'd99, 8'h99, 1'b0, "b99");
        conv_b(8'd100, 8'h00, 1'b1, "b100");
        conv_b(8'd7, 8'h07, 1'b0, "b7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
